trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Machine-mode trap controller for the RV32I core. It sits beside the decode/execute stage and consumes the decoder's exception request, cause and return flags plus the external interrupt lines. It holds the trap CSRs (mstatus.MIE/MPIE, mie, mtvec, mepc, mcause) and sequences trap entry, `mret` and `wfi` by stalling, flushing and redirecting the fetch PC.

## Interface
- XLEN, 32, datapath width
- MTVEC_RESET, 32'h0000_0100, reset value of mtvec
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  instruction in execute is valid and may commit
- pc  in  XLEN  PC of that instruction
- exc_request  in  1  decoder exception (ecall/ebreak/invalid opcode)
- exc_cause  in  XLEN  decoder cause code
- exc_ret  in  1  instruction is `mret`
- wfi  in  1  instruction is `wfi`
- irq_timer, irq_ext  in  1 each  level-sensitive interrupt lines (mip.MTIP, mip.MEIP)
- csr_we  in  1  CSR write strobe from CSR unit
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  already-computed write value (RW/RS/RC resolved upstream)
- csr_rdata  out  XLEN  combinational read of csr_addr; 0 for unhandled addresses
- stall  out  1  hold fetch/decode/execute
- flush  out  1  squash instruction in execute and younger
- redirect_valid  out  1  load redirect_pc into PC this cycle
- redirect_pc  out  XLEN  new PC

## Operation
- States: RUN, SAVE, JUMP, WFI_WAIT.
- Event evaluation only in RUN with instr_valid=1. Priority: exception > interrupt > mret > wfi > CSR write.
- Interrupt pending: int_p = (irq_ext & mie.MEIE) | (irq_timer & mie.MTIE). Taken when mstatus.MIE & int_p. Cause: ext 32'h8000_000B beats timer 32'h8000_0007.
- Exception/interrupt: RUN→SAVE. In SAVE: mepc←pc (latched at detection), mcause←cause, MPIE←MIE, MIE←0; then →JUMP. In JUMP: redirect_pc = {mtvec[31:2],2'b00}; →RUN.
- mret: RUN→JUMP with redirect_pc=mepc; MIE←MPIE, MPIE←1 on the JUMP cycle.
- wfi: RUN→WFI_WAIT. Leave when int_p=1 (regardless of MIE). If MIE=1, go to SAVE with mepc=pc+4 and the interrupt cause; else →RUN with no redirect.
- CSR writes accepted only in RUN when no trap/mret/wfi event wins; a write coinciding with an exception is dropped. mepc write forces bit[1:0]=0; mtvec write forces bit[1:0]=0 (direct mode only). mip read-only, reads {irq_ext at 11, irq_timer at 7}.
- Inputs other than irq lines ignored outside RUN.

## Timing
- Reset: state RUN; mstatus, mie, mepc, mcause = 0; mtvec = MTVEC_RESET; stall, flush, redirect_valid = 0; redirect_pc = 0.
- Trap detected cycle N: flush=1 and stall=1 combinationally in N; SAVE in N+1 (stall=1); JUMP in N+2 (redirect_valid=1, stall=0); fetch of handler at N+3.
- mret detected N: flush=1 in N; JUMP in N+1 with redirect_valid=1.
- WFI_WAIT: stall=1 every cycle; int_p seen at cycle M → SAVE at M+1 or RUN at M+1.
- CSR state updates visible on csr_rdata the cycle after the write.
- rst asserted mid-sequence: immediate return to reset values; no partial CSR update survives.

## Structure
- Common package gains: trap_state_t enum, CSR address constants (0x300, 0x304, 0x305, 0x341, 0x342, 0x344), cause constants (ECALL 11, ILLEGAL 2, BREAKPOINT 3, MTI, MEI).
- One sub-module: trap_csr_regs (CSR storage, write masking, read mux); FSM and priority logic in trap_sequencer.

## Test plan
- ECALL at pc=0x200, exc_cause=11, mtvec=0x100 -> flush at N, mepc=0x200, mcause=11, MIE=0, redirect 0x100 at N+2.
- MIE=1, MEIE=1, MTIE=1, both irqs high at pc=0x40 -> mcause=0x8000000B, mepc=0x40, redirect to mtvec.
- mret with mepc=0x204, MPIE=1 -> redirect_valid at N+1 to 0x204, MIE=1, MPIE=1.
- wfi at pc=0x80, MIE=0, MTIE=1; irq_timer rises 5 cycles later -> stall 5 cycles, resume with no redirect; with MIE=1 -> mepc=0x84, mcause=0x80000007.
- CSR write mtvec=0x303 same cycle as exc_request -> write dropped; alone -> mtvec reads 0x300.
- rst pulse during SAVE -> all outputs 0, mtvec=MTVEC_RESET, mepc=0.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_sequencer_pkg;

   typedef enum logic [1:0] {
      S_RUN,
      S_SAVE,
      S_JUMP,
      S_WFI_WAIT
   } trap_state_t;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
   localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
   localparam logic [31:0] CAUSE_ECALL      = 32'd11;
   localparam logic [31:0] CAUSE_MTI        = 32'h8000_0007;
   localparam logic [31:0] CAUSE_MEI        = 32'h8000_000B;

   localparam int unsigned MSTATUS_MIE_BIT  = 3;
   localparam int unsigned MSTATUS_MPIE_BIT = 7;
   localparam int unsigned MIE_MTIE_BIT     = 7;
   localparam int unsigned MIE_MEIE_BIT     = 11;
   localparam int unsigned MIP_MTIP_BIT     = 7;
   localparam int unsigned MIP_MEIP_BIT     = 11;

endpackage

// File: rtl/trap_csr_regs.sv
// Trap CSR storage: mstatus.MIE/MPIE, mie, mtvec, mepc, mcause, plus read mux.
module trap_csr_regs
   import trap_sequencer_pkg::*;
#(
   parameter int unsigned        XLEN        = 32,
   parameter logic [XLEN-1:0]    MTVEC_RESET = 32'h0000_0100
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [11:0]      addr_i,
   input  logic [XLEN-1:0]  wdata_i,
   input  logic             save_i,
   input  logic [XLEN-1:0]  save_pc_i,
   input  logic [XLEN-1:0]  save_cause_i,
   input  logic             mret_i,
   input  logic             irq_timer_i,
   input  logic             irq_ext_i,
   output logic [XLEN-1:0]  rdata_o,
   output logic             mie_o,
   output logic             meie_o,
   output logic             mtie_o,
   output logic [XLEN-1:0]  mtvec_o,
   output logic [XLEN-1:0]  mepc_o
);

   logic            mie_q;
   logic            mpie_q;
   logic            meie_q;
   logic            mtie_q;
   logic [XLEN-1:0] mtvec_q;
   logic [XLEN-1:0] mepc_q;
   logic [XLEN-1:0] mcause_q;

   // Trap save and mret never coincide with a CSR write; ordering only documents intent.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mie_q    <= 1'b0;
         mpie_q   <= 1'b0;
         meie_q   <= 1'b0;
         mtie_q   <= 1'b0;
         mtvec_q  <= MTVEC_RESET;
         mepc_q   <= '0;
         mcause_q <= '0;
      end else if (save_i) begin
         mepc_q   <= save_pc_i;
         mcause_q <= save_cause_i;
         mpie_q   <= mie_q;
         mie_q    <= 1'b0;
      end else if (mret_i) begin
         mie_q    <= mpie_q;
         mpie_q   <= 1'b1;
      end else if (we_i) begin
         case (addr_i)
            CSR_MSTATUS: begin
               mie_q  <= wdata_i[MSTATUS_MIE_BIT];
               mpie_q <= wdata_i[MSTATUS_MPIE_BIT];
            end
            CSR_MIE: begin
               meie_q <= wdata_i[MIE_MEIE_BIT];
               mtie_q <= wdata_i[MIE_MTIE_BIT];
            end
            CSR_MTVEC:  mtvec_q  <= {wdata_i[XLEN-1:2], 2'b00};
            CSR_MEPC:   mepc_q   <= {wdata_i[XLEN-1:2], 2'b00};
            CSR_MCAUSE: mcause_q <= wdata_i;
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata_o = '0;
      case (addr_i)
         CSR_MSTATUS: begin
            rdata_o[MSTATUS_MIE_BIT]  = mie_q;
            rdata_o[MSTATUS_MPIE_BIT] = mpie_q;
         end
         CSR_MIE: begin
            rdata_o[MIE_MEIE_BIT] = meie_q;
            rdata_o[MIE_MTIE_BIT] = mtie_q;
         end
         CSR_MTVEC:  rdata_o = mtvec_q;
         CSR_MEPC:   rdata_o = mepc_q;
         CSR_MCAUSE: rdata_o = mcause_q;
         CSR_MIP: begin
            rdata_o[MIP_MEIP_BIT] = irq_ext_i;
            rdata_o[MIP_MTIP_BIT] = irq_timer_i;
         end
         default: ;
      endcase
   end

   assign mie_o   = mie_q;
   assign meie_o  = meie_q;
   assign mtie_o  = mtie_q;
   assign mtvec_o = mtvec_q;
   assign mepc_o  = mepc_q;

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: event priority, trap entry/mret/wfi FSM,
// pipeline stall/flush and fetch redirect.
module trap_sequencer
   import trap_sequencer_pkg::*;
#(
   parameter int unsigned        XLEN        = 32,
   parameter logic [XLEN-1:0]    MTVEC_RESET = 32'h0000_0100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [XLEN-1:0]  pc,
   input  logic             exc_request,
   input  logic [XLEN-1:0]  exc_cause,
   input  logic             exc_ret,
   input  logic             wfi,
   input  logic             irq_timer,
   input  logic             irq_ext,
   input  logic             csr_we,
   input  logic [11:0]      csr_addr,
   input  logic [XLEN-1:0]  csr_wdata,
   output logic [XLEN-1:0]  csr_rdata,
   output logic             stall,
   output logic             flush,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc
);

   trap_state_t     state_q;
   logic [XLEN-1:0] trap_pc_q;
   logic [XLEN-1:0] trap_cause_q;
   logic            redirect_valid_q;
   logic [XLEN-1:0] redirect_pc_q;
   logic            mret_jump_q;

   logic            status_mie;
   logic            meie;
   logic            mtie;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc;

   logic            int_p;
   logic [XLEN-1:0] int_cause;
   logic            in_run;
   logic            take_exc;
   logic            take_int;
   logic            take_mret;
   logic            take_wfi;
   logic            take_csr;

   always_comb begin
      int_p     = (irq_ext & meie) | (irq_timer & mtie);
      int_cause = (irq_ext & meie) ? CAUSE_MEI : CAUSE_MTI;
      in_run    = (state_q == S_RUN) && instr_valid;
      take_exc  = in_run && exc_request;
      take_int  = in_run && !exc_request && status_mie && int_p;
      take_mret = in_run && !exc_request && !(status_mie && int_p) && exc_ret;
      take_wfi  = in_run && !exc_request && !(status_mie && int_p) && !exc_ret && wfi;
      take_csr  = in_run && !exc_request && !(status_mie && int_p) && !exc_ret && !wfi
                  && csr_we;
      stall     = take_exc || take_int || (state_q == S_SAVE) || (state_q == S_WFI_WAIT);
      flush     = take_exc || take_int || take_mret;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= S_RUN;
         trap_pc_q        <= '0;
         trap_cause_q     <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         mret_jump_q      <= 1'b0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (take_exc || take_int) begin
                  trap_pc_q    <= pc;
                  trap_cause_q <= take_exc ? exc_cause : int_cause;
                  state_q      <= S_SAVE;
               end else if (take_mret) begin
                  state_q          <= S_JUMP;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= mepc;
                  mret_jump_q      <= 1'b1;
               end else if (take_wfi) begin
                  // An interrupt that ends the wait returns to the instruction after wfi.
                  trap_pc_q <= pc + XLEN'(4);
                  state_q   <= S_WFI_WAIT;
               end
            end
            S_SAVE: begin
               state_q          <= S_JUMP;
               redirect_valid_q <= 1'b1;
               redirect_pc_q    <= {mtvec[XLEN-1:2], 2'b00};
               mret_jump_q      <= 1'b0;
            end
            S_JUMP: begin
               state_q          <= S_RUN;
               redirect_valid_q <= 1'b0;
               redirect_pc_q    <= '0;
               mret_jump_q      <= 1'b0;
            end
            S_WFI_WAIT: begin
               if (int_p) begin
                  if (status_mie) begin
                     trap_cause_q <= int_cause;
                     state_q      <= S_SAVE;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
            default: state_q <= S_RUN;
         endcase
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

   trap_csr_regs #(
      .XLEN        (XLEN),
      .MTVEC_RESET (MTVEC_RESET)
   ) u_csr (
      .clk_i        (clk),
      .rst_i        (rst),
      .we_i         (take_csr),
      .addr_i       (csr_addr),
      .wdata_i      (csr_wdata),
      .save_i       (state_q == S_SAVE),
      .save_pc_i    (trap_pc_q),
      .save_cause_i (trap_cause_q),
      .mret_i       ((state_q == S_JUMP) && mret_jump_q),
      .irq_timer_i  (irq_timer),
      .irq_ext_i    (irq_ext),
      .rdata_o      (csr_rdata),
      .mie_o        (status_mie),
      .meie_o       (meie),
      .mtie_o       (mtie),
      .mtvec_o      (mtvec),
      .mepc_o       (mepc)
   );

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed plus randomized checks of trap_sequencer against a transaction-level CSR model.
module tb_trap_sequencer;
   import trap_sequencer_pkg::*;

   localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid, exc_request, exc_ret, wfi, irq_timer, irq_ext, csr_we;
   logic [31:0] pc, exc_cause, csr_wdata, csr_rdata, redirect_pc;
   logic [11:0] csr_addr;
   logic        stall, flush, redirect_valid;

   int vectors     = 0;
   int miscompares = 0;

   bit          m_mie, m_mpie, m_meie, m_mtie;
   logic [31:0] m_mtvec, m_mepc, m_mcause;

   trap_sequencer #(.XLEN(32), .MTVEC_RESET(MTVEC_RST)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc(pc),
      .exc_request(exc_request), .exc_cause(exc_cause), .exc_ret(exc_ret), .wfi(wfi),
      .irq_timer(irq_timer), .irq_ext(irq_ext), .csr_we(csr_we), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mie = 0; m_mpie = 0; m_meie = 0; m_mtie = 0;
      m_mtvec = MTVEC_RST; m_mepc = 0; m_mcause = 0;
   endtask

   task automatic model_write(input logic [11:0] a, input logic [31:0] d);
      case (a)
         CSR_MSTATUS: begin m_mie = d[3]; m_mpie = d[7]; end
         CSR_MIE:     begin m_meie = d[11]; m_mtie = d[7]; end
         CSR_MTVEC:   m_mtvec = d & ~32'h3;
         CSR_MEPC:    m_mepc = d & ~32'h3;
         CSR_MCAUSE:  m_mcause = d;
         default: ;
      endcase
   endtask

   function automatic logic [31:0] exp_read(input logic [11:0] a);
      case (a)
         CSR_MSTATUS: return (32'(m_mpie) << 7) | (32'(m_mie) << 3);
         CSR_MIE:     return (32'(m_meie) << 11) | (32'(m_mtie) << 7);
         CSR_MTVEC:   return m_mtvec;
         CSR_MEPC:    return m_mepc;
         CSR_MCAUSE:  return m_mcause;
         CSR_MIP:     return (32'(irq_ext) << 11) | (32'(irq_timer) << 7);
         default:     return 32'h0;
      endcase
   endfunction

   task automatic idle();
      instr_valid = 0; exc_request = 0; exc_ret = 0; wfi = 0; csr_we = 0;
   endtask

   task automatic check_csrs();
      logic [11:0] addrs [7];
      addrs = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MIP, 12'h7C0};
      foreach (addrs[i]) begin
         @(negedge clk); idle(); csr_addr = addrs[i];
         #1 chk($sformatf("csr_rd_%h", addrs[i]), csr_rdata, exp_read(addrs[i]));
      end
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk); idle();
      instr_valid = 1; csr_we = 1; csr_addr = a; csr_wdata = d;
      #1 chk("csrw_stall", 32'(stall), 0);
      chk("csrw_flush", 32'(flush), 0);
      model_write(a, d);
      @(negedge clk); idle(); csr_addr = a;
      #1 chk($sformatf("csrw_readback_%h", a), csr_rdata, exp_read(a));
   endtask

   task automatic take_trap(input logic [31:0] tpc, input bit is_exc,
                            input logic [31:0] cause, input bit with_csr);
      logic [31:0] exp_cause;
      @(negedge clk); idle();
      instr_valid = 1; pc = tpc; exc_request = is_exc; exc_cause = cause;
      if (with_csr) begin csr_we = 1; csr_addr = CSR_MTVEC; csr_wdata = 32'h303; end
      exp_cause = is_exc ? cause : ((irq_ext && m_meie) ? CAUSE_MEI : CAUSE_MTI);
      #1 chk("trap_flush_N", 32'(flush), 1);
      chk("trap_stall_N", 32'(stall), 1);
      chk("trap_rv_N", 32'(redirect_valid), 0);
      @(negedge clk); idle();
      #1 chk("trap_stall_N1", 32'(stall), 1);
      chk("trap_flush_N1", 32'(flush), 0);
      chk("trap_rv_N1", 32'(redirect_valid), 0);
      m_mepc = tpc; m_mcause = exp_cause; m_mpie = m_mie; m_mie = 0;
      @(negedge clk);
      #1 chk("trap_rv_N2", 32'(redirect_valid), 1);
      chk("trap_rpc_N2", redirect_pc, m_mtvec);
      chk("trap_stall_N2", 32'(stall), 0);
      @(negedge clk);
      #1 chk("trap_rv_N3", 32'(redirect_valid), 0);
   endtask

   task automatic do_mret();
      @(negedge clk); idle();
      instr_valid = 1; exc_ret = 1;
      #1 chk("mret_flush_N", 32'(flush), 1);
      chk("mret_rv_N", 32'(redirect_valid), 0);
      @(negedge clk); idle();
      #1 chk("mret_rv_N1", 32'(redirect_valid), 1);
      chk("mret_rpc_N1", redirect_pc, m_mepc);
      chk("mret_stall_N1", 32'(stall), 0);
      m_mie = m_mpie; m_mpie = 1;
      @(negedge clk); csr_addr = CSR_MSTATUS;
      #1 chk("mret_rv_N2", 32'(redirect_valid), 0);
      chk("mret_mstatus", csr_rdata, exp_read(CSR_MSTATUS));
   endtask

   task automatic do_wfi(input logic [31:0] wpc, input int delay, input bit ext);
      @(negedge clk); idle();
      instr_valid = 1; wfi = 1; pc = wpc;
      #1 chk("wfi_stall_N", 32'(stall), 0);
      for (int k = 1; k <= delay; k++) begin
         @(negedge clk); idle();
         if (k == delay) begin
            if (ext) irq_ext = 1; else irq_timer = 1;
         end
         #1 chk("wfi_wait_stall", 32'(stall), 1);
         chk("wfi_wait_rv", 32'(redirect_valid), 0);
      end
      @(negedge clk); irq_ext = 0; irq_timer = 0;
      if (m_mie) begin
         #1 chk("wfi_save_stall", 32'(stall), 1);
         m_mepc = wpc + 4; m_mcause = ext ? CAUSE_MEI : CAUSE_MTI;
         m_mpie = m_mie; m_mie = 0;
         @(negedge clk);
         #1 chk("wfi_trap_rv", 32'(redirect_valid), 1);
         chk("wfi_trap_rpc", redirect_pc, m_mtvec);
         @(negedge clk);
         #1 chk("wfi_trap_rv_end", 32'(redirect_valid), 0);
      end else begin
         #1 chk("wfi_resume_stall", 32'(stall), 0);
         chk("wfi_resume_rv", 32'(redirect_valid), 0);
      end
   endtask

   initial begin
      logic [11:0] waddrs [7];
      logic [1:0]  lines, en;
      bit          ext;
      waddrs = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MIP, 12'h7C0};

      rst = 1; irq_timer = 0; irq_ext = 0; pc = 0; exc_cause = 0;
      csr_addr = 0; csr_wdata = 0; idle(); model_reset();
      #2 chk("rst_stall", 32'(stall), 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_rv", 32'(redirect_valid), 0);
      chk("rst_rpc", redirect_pc, 0);
      @(negedge clk); rst = 0;
      check_csrs();

      // ECALL with reset mtvec
      take_trap(32'h200, 1, CAUSE_ECALL, 0);
      check_csrs();

      // External beats timer when both pending
      csr_write(CSR_MSTATUS, 32'h8);
      csr_write(CSR_MIE, 32'h880);
      irq_ext = 1; irq_timer = 1;
      take_trap(32'h40, 0, 0, 0);
      check_csrs();
      irq_ext = 0; irq_timer = 0;

      // mret restores MIE from MPIE
      csr_write(CSR_MEPC, 32'h204);
      csr_write(CSR_MSTATUS, 32'h80);
      do_mret();
      check_csrs();

      // wfi without and with global enable
      csr_write(CSR_MSTATUS, 32'h0);
      csr_write(CSR_MIE, 32'h80);
      do_wfi(32'h80, 5, 0);
      csr_write(CSR_MSTATUS, 32'h8);
      do_wfi(32'h80, 5, 0);
      check_csrs();

      // CSR write with an exception is dropped; alone it lands with low bits cleared
      take_trap(32'h10, 1, CAUSE_ILLEGAL, 1);
      check_csrs();
      csr_write(CSR_MTVEC, 32'h303);
      take_trap(32'h14, 1, CAUSE_BREAKPOINT, 0);

      // Reset while in SAVE
      @(negedge clk); idle(); instr_valid = 1; exc_request = 1; pc = 32'h300; exc_cause = 5;
      @(negedge clk); idle();
      #1 chk("pre_rst_save_stall", 32'(stall), 1);
      #1 rst = 1; csr_addr = CSR_MTVEC;
      #1 chk("midrst_stall", 32'(stall), 0);
      chk("midrst_flush", 32'(flush), 0);
      chk("midrst_rv", 32'(redirect_valid), 0);
      chk("midrst_rpc", redirect_pc, 0);
      chk("midrst_mtvec", csr_rdata, MTVEC_RST);
      @(negedge clk); rst = 0; model_reset();
      check_csrs();

      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 4))
            0: csr_write(waddrs[$urandom_range(0, 6)], $urandom);
            1: take_trap($urandom & ~32'h3, 1, 32'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            2: begin
               lines = 2'($urandom_range(1, 3));
               en    = 2'($urandom_range(1, 3));
               if ((lines & en) == 2'b00) en = lines;
               csr_write(CSR_MSTATUS, 32'h8 | (32'($urandom_range(0, 1)) << 7));
               csr_write(CSR_MIE, (32'(en[1]) << 11) | (32'(en[0]) << 7));
               irq_ext = lines[1]; irq_timer = lines[0];
               take_trap($urandom & ~32'h3, 0, 0, 0);
               irq_ext = 0; irq_timer = 0;
            end
            3: begin
               csr_write(CSR_MEPC, $urandom);
               do_mret();
            end
            default: begin
               ext = 1'($urandom_range(0, 1));
               csr_write(CSR_MSTATUS, 32'($urandom_range(0, 1)) << 3);
               csr_write(CSR_MIE, ext ? 32'h800 : 32'h80);
               do_wfi($urandom & ~32'h3, $urandom_range(1, 6), ext);
            end
         endcase
         check_csrs();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
